// File: rtl/nn_mem_pkg.sv
// Shared types and constants for the nn_mem_ctrl loader/arbiter.
// Optional feature macro: NN_MEM_LOADMAP_EN.
package nn_mem_pkg;

    localparam int W_ADDR_LEN_D = 20;
    localparam int W_SEL_LEN_D  = 2;
    localparam int X_ADDR_LEN_D = 10;
    localparam int X_SEL_LEN_D  = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        COMPUTE
    } state_t;

    localparam logic TGT_W = 1'b0;
    localparam logic TGT_X = 1'b1;

    localparam int LM_W_BASE = 0;
    localparam int LM_X_BASE = 4;

    // Bit of loaded_map that tracks bank (tgt, sel).
    function automatic logic [2:0] lm_index(input logic tgt, input logic [1:0] sel);
        logic [2:0] base;
        base = tgt ? 3'(LM_X_BASE) : 3'(LM_W_BASE);
        return base + {1'b0, sel};
    endfunction

endpackage

// File: rtl/nn_mem_port_mux.sv
// Owner-selected mux of loader registers vs compute requests onto mem_sys.
// Purely combinational; the owner flag comes from the top-level FSM.
module nn_mem_port_mux
    import nn_mem_pkg::*;
#(
    parameter int W_ADDR_LEN = W_ADDR_LEN_D,
    parameter int W_SEL_LEN  = W_SEL_LEN_D,
    parameter int X_ADDR_LEN = X_ADDR_LEN_D,
    parameter int X_SEL_LEN  = X_SEL_LEN_D
) (
    input  logic                  i_compute,
    input  logic                  i_l_we_w,
    input  logic                  i_l_we_x,
    input  logic [W_ADDR_LEN-1:0] i_l_address_w,
    input  logic [X_ADDR_LEN-1:0] i_l_address_x,
    input  logic [W_SEL_LEN-1:0]  i_l_sel_w,
    input  logic [X_SEL_LEN-1:0]  i_l_sel_x,
    input  logic                  i_l_data_in,
    input  logic                  i_c_we_w,
    input  logic                  i_c_we_x,
    input  logic [W_ADDR_LEN-1:0] i_c_address_w,
    input  logic [X_ADDR_LEN-1:0] i_c_address_x,
    input  logic [W_SEL_LEN-1:0]  i_c_sel_w,
    input  logic [X_SEL_LEN-1:0]  i_c_sel_x,
    input  logic                  i_c_data_in,
    output logic                  o_we_w,
    output logic                  o_we_x,
    output logic [W_ADDR_LEN-1:0] o_address_w,
    output logic [X_ADDR_LEN-1:0] o_address_x,
    output logic [W_SEL_LEN-1:0]  o_sel_w,
    output logic [X_SEL_LEN-1:0]  o_sel_x,
    output logic                  o_data_in
);

    assign o_we_w      = i_compute ? i_c_we_w      : i_l_we_w;
    assign o_we_x      = i_compute ? i_c_we_x      : i_l_we_x;
    assign o_address_w = i_compute ? i_c_address_w : i_l_address_w;
    assign o_address_x = i_compute ? i_c_address_x : i_l_address_x;
    assign o_sel_w     = i_compute ? i_c_sel_w     : i_l_sel_w;
    assign o_sel_x     = i_compute ? i_c_sel_x     : i_l_sel_x;
    assign o_data_in   = i_compute ? i_c_data_in   : i_l_data_in;

endmodule

// File: rtl/nn_mem_ctrl.sv
// Load sequencer and mem_sys port arbiter between serial loader and compute.
// Define NN_MEM_LOADMAP_EN to add loaded_map and gate start_compute on it.
module nn_mem_ctrl
    import nn_mem_pkg::*;
#(
    parameter int W_ADDR_LEN = W_ADDR_LEN_D,
    parameter int W_SEL_LEN  = W_SEL_LEN_D,
    parameter int X_ADDR_LEN = X_ADDR_LEN_D,
    parameter int X_SEL_LEN  = X_SEL_LEN_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_target,
    input  logic [W_SEL_LEN-1:0]  cmd_sel,
    input  logic [W_ADDR_LEN-1:0] cmd_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_data,
    output logic                  load_done,
    input  logic                  start_compute,
    output logic                  compute_busy,
    input  logic                  compute_finish,
    input  logic                  c_we_w,
    input  logic                  c_we_x,
    input  logic [W_ADDR_LEN-1:0] c_address_w,
    input  logic [X_ADDR_LEN-1:0] c_address_x,
    input  logic [W_SEL_LEN-1:0]  c_sel_w,
    input  logic [X_SEL_LEN-1:0]  c_sel_x,
    input  logic                  c_data_in,
    output logic                  we_w,
    output logic                  we_x,
    output logic [W_ADDR_LEN-1:0] address_w,
    output logic [X_ADDR_LEN-1:0] address_x,
    output logic [W_SEL_LEN-1:0]  sel_w,
    output logic [X_SEL_LEN-1:0]  sel_x,
    output logic                  data_in
`ifdef NN_MEM_LOADMAP_EN
    ,
    output logic [7:0]            loaded_map
`endif
);

    state_t                r_state;
    logic [W_SEL_LEN-1:0]  r_sel;
    logic [W_ADDR_LEN-1:0] r_last;
    logic [W_ADDR_LEN-1:0] r_cnt;
    logic                  r_load_done;
    logic                  r_we_w;
    logic                  r_we_x;
    logic [W_ADDR_LEN-1:0] r_addr_w;
    logic [X_ADDR_LEN-1:0] r_addr_x;
    logic [W_SEL_LEN-1:0]  r_sel_w;
    logic [X_SEL_LEN-1:0]  r_sel_x;
    logic                  r_data;

    logic                  w_loading;
    logic                  w_at_last;
    logic                  w_start_ok;
    logic                  w_compute;

`ifdef NN_MEM_LOADMAP_EN
    logic [7:0]            r_map;
    assign loaded_map = r_map;
    assign w_start_ok = (r_map == 8'hFF);
`else
    assign w_start_ok = 1'b1;
`endif

    assign w_loading    = (r_state == LOAD_W) || (r_state == LOAD_X);
    assign w_compute    = (r_state == COMPUTE);
    assign cmd_ready    = (r_state == IDLE);
    assign s_ready      = w_loading;
    assign compute_busy = w_compute;
    assign load_done    = r_load_done;

    // X loads wrap on the X address width, so only those LSBs are compared.
    assign w_at_last = (r_state == LOAD_X)
                     ? (X_ADDR_LEN'(r_cnt) == X_ADDR_LEN'(r_last))
                     : (r_cnt == r_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_last      <= '0;
            r_cnt       <= '0;
            r_load_done <= 1'b0;
            r_we_w      <= 1'b0;
            r_we_x      <= 1'b0;
            r_addr_w    <= '0;
            r_addr_x    <= '0;
            r_sel_w     <= '0;
            r_sel_x     <= '0;
            r_data      <= 1'b0;
`ifdef NN_MEM_LOADMAP_EN
            r_map       <= '0;
`endif
        end else begin
            r_load_done <= 1'b0;
            r_we_w      <= 1'b0;
            r_we_x      <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_sel   <= cmd_sel;
                        r_last  <= cmd_last;
                        r_cnt   <= '0;
                        r_state <= (cmd_target == TGT_X) ? LOAD_X : LOAD_W;
                    end else if (start_compute && w_start_ok) begin
                        r_state <= COMPUTE;
                    end
                end
                LOAD_W, LOAD_X: begin
                    if (s_valid) begin
                        if (r_state == LOAD_W) begin
                            r_we_w   <= 1'b1;
                            r_addr_w <= r_cnt;
                            r_sel_w  <= r_sel;
                        end else begin
                            r_we_x   <= 1'b1;
                            r_addr_x <= X_ADDR_LEN'(r_cnt);
                            r_sel_x  <= X_SEL_LEN'(r_sel);
                        end
                        r_data <= s_data;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_at_last) begin
                            r_load_done <= 1'b1;
                            r_state     <= IDLE;
`ifdef NN_MEM_LOADMAP_EN
                            r_map[lm_index(r_state == LOAD_X, 2'(r_sel))] <= 1'b1;
`endif
                        end
                    end
                end
                COMPUTE: begin
                    if (compute_finish) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    nn_mem_port_mux #(
        .W_ADDR_LEN (W_ADDR_LEN),
        .W_SEL_LEN  (W_SEL_LEN),
        .X_ADDR_LEN (X_ADDR_LEN),
        .X_SEL_LEN  (X_SEL_LEN)
    ) u_mux (
        .i_compute     (w_compute),
        .i_l_we_w      (r_we_w),
        .i_l_we_x      (r_we_x),
        .i_l_address_w (r_addr_w),
        .i_l_address_x (r_addr_x),
        .i_l_sel_w     (r_sel_w),
        .i_l_sel_x     (r_sel_x),
        .i_l_data_in   (r_data),
        .i_c_we_w      (c_we_w),
        .i_c_we_x      (c_we_x),
        .i_c_address_w (c_address_w),
        .i_c_address_x (c_address_x),
        .i_c_sel_w     (c_sel_w),
        .i_c_sel_x     (c_sel_x),
        .i_c_data_in   (c_data_in),
        .o_we_w        (we_w),
        .o_we_x        (we_x),
        .o_address_w   (address_w),
        .o_address_x   (address_x),
        .o_sel_w       (sel_w),
        .o_sel_x       (sel_x),
        .o_data_in     (data_in)
    );

endmodule
